// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage (master)
// and instruction memory (slave).
interface if_fetch_stage_if;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemReady;
    logic [31:0] IMemRData;

    modport master (
        output IMemReq,
        output IMemAddr,
        input  IMemReady,
        input  IMemRData
    );

    modport slave (
        input  IMemReq,
        input  IMemAddr,
        output IMemReady,
        output IMemRData
    );
endinterface

// File: rtl/if_fetch_stage.sv
// MIPS IF stage: PC ownership, next-PC selection and instruction-memory handshake.
// Optional macro IF_ALIGN_TRAP_EN adds a sticky AlignTrap output for misaligned redirects.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               PCWrite,
    input  logic               BranchTaken,
    input  logic [31:0]        BranchTarget,
    input  logic               Jump,
    input  logic [31:0]        JumpTarget,
    if_fetch_stage_if.master   imem,
    output logic [31:0]        Inst,
    output logic [31:0]        PC_Plus4,
    output logic               InstValid,
    output logic               Flush
`ifdef IF_ALIGN_TRAP_EN
    ,
    output logic               AlignTrap
`endif
);

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [31:0] pc, pc_next;
    logic [31:0] pc_plus;
    logic [31:0] hold_buf, hold_buf_next;
    logic [31:0] drain_addr, drain_addr_next;
    logic        redirect;
    logic [31:0] target;
    logic [31:0] target_aligned;

    assign pc_plus        = pc + 32'd4;
    assign redirect       = BranchTaken | Jump;
    assign target         = BranchTaken ? BranchTarget : JumpTarget;
    assign target_aligned = {target[31:2], 2'b00};

    always_comb begin
        state_next      = state;
        pc_next         = pc;
        hold_buf_next   = hold_buf;
        drain_addr_next = drain_addr;
        imem.IMemReq    = 1'b0;
        imem.IMemAddr   = pc;
        InstValid       = 1'b0;
        Inst            = 32'h0;
        PC_Plus4        = pc_plus;
        Flush           = 1'b0;

        if (!reset) begin
            Flush = redirect;
            case (state)
                REQ: begin
                    imem.IMemReq = 1'b1;
                    if (redirect) begin
                        pc_next = target_aligned;
                        if (!imem.IMemReady) begin
                            drain_addr_next = pc;
                            state_next      = DRAIN;
                        end
                    end else if (imem.IMemReady) begin
                        InstValid = 1'b1;
                        Inst      = imem.IMemRData;
                        if (PCWrite) begin
                            pc_next = pc_plus;
                        end else begin
                            hold_buf_next = imem.IMemRData;
                            state_next    = HOLD;
                        end
                    end
                end

                HOLD: begin
                    if (redirect) begin
                        pc_next    = target_aligned;
                        state_next = REQ;
                    end else begin
                        InstValid = 1'b1;
                        Inst      = hold_buf;
                        if (PCWrite) begin
                            pc_next    = pc_plus;
                            state_next = REQ;
                        end
                    end
                end

                DRAIN: begin
                    // The abandoned request must be completed before the target is fetched.
                    imem.IMemReq  = 1'b1;
                    imem.IMemAddr = drain_addr;
                    if (redirect) begin
                        pc_next = target_aligned;
                    end
                    if (imem.IMemReady) begin
                        state_next = REQ;
                    end
                end

                default: state_next = REQ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= REQ;
            pc    <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    // NOTE: pure datapath registers are only read after being written, so they skip reset.
    always_ff @(posedge clock) begin
        hold_buf   <= hold_buf_next;
        drain_addr <= drain_addr_next;
    end

`ifdef IF_ALIGN_TRAP_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            AlignTrap <= 1'b0;
        end else if (redirect && (target[1:0] != 2'b00)) begin
            AlignTrap <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: expected outputs are queued per step and
// checked with immediate assertions when the cycle's outputs settle.
module tb_if_fetch_stage;

    logic        clock;
    logic        reset;
    logic        PCWrite;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        Jump;
    logic [31:0] JumpTarget;
    logic [31:0] Inst;
    logic [31:0] PC_Plus4;
    logic        InstValid;
    logic        Flush;
    logic        ready;
`ifdef IF_ALIGN_TRAP_EN
    logic        AlignTrap;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        chk_addr;
        logic        valid;
        logic [31:0] pc4;
        logic        flush;
        logic        trap;
    } exp_t;

    exp_t sb[$];

    if_fetch_stage_if imem ();

    function automatic logic [31:0] mw(input logic [31:0] a);
        return a ^ 32'h8C00_0001;
    endfunction

    assign imem.IMemReady = ready;
    assign imem.IMemRData = mw(imem.IMemAddr);

    if_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clock        (clock),
        .reset        (reset),
        .PCWrite      (PCWrite),
        .BranchTaken  (BranchTaken),
        .BranchTarget (BranchTarget),
        .Jump         (Jump),
        .JumpTarget   (JumpTarget),
        .imem         (imem.master),
        .Inst         (Inst),
        .PC_Plus4     (PC_Plus4),
        .InstValid    (InstValid),
        .Flush        (Flush)
`ifdef IF_ALIGN_TRAP_EN
        ,
        .AlignTrap    (AlignTrap)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    int step_no = 0;

    task automatic step(
        input logic rst, input logic pcw,
        input logic br, input logic [31:0] bt,
        input logic j, input logic [31:0] jt,
        input logic rdy,
        input logic e_req, input logic [31:0] e_addr, input logic e_chk_addr,
        input logic e_valid, input logic [31:0] e_pc4, input logic e_flush,
        input logic e_trap
    );
        exp_t e;
        logic [31:0] e_inst;
        reset        = rst;
        PCWrite      = pcw;
        BranchTaken  = br;
        BranchTarget = bt;
        Jump         = j;
        JumpTarget   = jt;
        ready        = rdy;
        sb.push_back('{e_req, e_addr, e_chk_addr, e_valid, e_pc4, e_flush, e_trap});
        @(negedge clock);
        step_no++;
        e = sb.pop_front();
        e_inst = e.valid ? mw(e.pc4 - 32'd4) : 32'h0;
        check($sformatf("s%0d_req", step_no), {31'b0, imem.IMemReq}, {31'b0, e.req});
        if (e.chk_addr) check($sformatf("s%0d_addr", step_no), imem.IMemAddr, e.addr);
        check($sformatf("s%0d_valid", step_no), {31'b0, InstValid}, {31'b0, e.valid});
        check($sformatf("s%0d_inst", step_no), Inst, e_inst);
        if (e.valid) check($sformatf("s%0d_pc4", step_no), PC_Plus4, e.pc4);
        check($sformatf("s%0d_flush", step_no), {31'b0, Flush}, {31'b0, e.flush});
`ifdef IF_ALIGN_TRAP_EN
        check($sformatf("s%0d_trap", step_no), {31'b0, AlignTrap}, {31'b0, e.trap});
`endif
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; PCWrite = 1'b1; BranchTaken = 1'b0; BranchTarget = '0;
        Jump = 1'b0; JumpTarget = '0; ready = 1'b1;
        @(posedge clock);
        #1;
        //   rst pcw br bt            j  jt            rdy  req addr          ca val pc4           fl trap
        step(1, 1, 0, 32'h0,        0, 32'h0,        1,   0, 32'h0,        0, 0, 32'h0,        0, 0);
        // zero-wait sequential fetch
        step(0, 1, 0, 32'h0,        0, 32'h0,        1,   1, 32'h0,        1, 1, 32'h4,        0, 0);
        step(0, 1, 0, 32'h0,        0, 32'h0,        1,   1, 32'h4,        1, 1, 32'h8,        0, 0);
        step(0, 1, 0, 32'h0,        0, 32'h0,        1,   1, 32'h8,        1, 1, 32'hC,        0, 0);
        step(0, 1, 0, 32'h0,        0, 32'h0,        1,   1, 32'hC,        1, 1, 32'h10,       0, 0);
        // reset beats a simultaneous branch
        step(1, 1, 1, 32'h200,      0, 32'h0,        1,   0, 32'h0,        0, 0, 32'h0,        0, 0);
        step(0, 1, 0, 32'h0,        0, 32'h0,        1,   1, 32'h0,        1, 1, 32'h4,        0, 0);
        step(0, 1, 0, 32'h0,        0, 32'h0,        1,   1, 32'h4,        1, 1, 32'h8,        0, 0);
        // two wait states at 0x8
        step(0, 1, 0, 32'h0,        0, 32'h0,        0,   1, 32'h8,        1, 0, 32'h0,        0, 0);
        step(0, 1, 0, 32'h0,        0, 32'h0,        0,   1, 32'h8,        1, 0, 32'h0,        0, 0);
        step(0, 1, 0, 32'h0,        0, 32'h0,        1,   1, 32'h8,        1, 1, 32'hC,        0, 0);
        step(0, 1, 0, 32'h0,        0, 32'h0,        1,   1, 32'hC,        1, 1, 32'h10,       0, 0);
        // stall while 0x10 returns -> HOLD
        step(0, 0, 0, 32'h0,        0, 32'h0,        1,   1, 32'h10,       1, 1, 32'h14,       0, 0);
        step(0, 0, 0, 32'h0,        0, 32'h0,        0,   0, 32'h0,        0, 1, 32'h14,       0, 0);
        step(0, 0, 0, 32'h0,        0, 32'h0,        0,   0, 32'h0,        0, 1, 32'h14,       0, 0);
        step(0, 1, 0, 32'h0,        0, 32'h0,        1,   0, 32'h0,        0, 1, 32'h14,       0, 0);
        step(0, 1, 0, 32'h0,        0, 32'h0,        1,   1, 32'h14,       1, 1, 32'h18,       0, 0);
        step(0, 1, 0, 32'h0,        0, 32'h0,        1,   1, 32'h18,       1, 1, 32'h1C,       0, 0);
        step(0, 1, 0, 32'h0,        0, 32'h0,        1,   1, 32'h1C,       1, 1, 32'h20,       0, 0);
        // branch to 0x40 while 0x20 waits -> DRAIN
        step(0, 1, 1, 32'h40,       0, 32'h0,        0,   1, 32'h20,       1, 0, 32'h0,        1, 0);
        step(0, 1, 0, 32'h0,        0, 32'h0,        0,   1, 32'h20,       1, 0, 32'h0,        0, 0);
        step(0, 1, 0, 32'h0,        0, 32'h0,        1,   1, 32'h20,       1, 0, 32'h0,        0, 0);
        step(0, 1, 0, 32'h0,        0, 32'h0,        1,   1, 32'h40,       1, 1, 32'h44,       0, 0);
        // branch beats jump
        step(0, 1, 1, 32'h80,       1, 32'h100,      1,   1, 32'h44,       1, 0, 32'h0,        1, 0);
        step(0, 1, 0, 32'h0,        0, 32'h0,        1,   1, 32'h80,       1, 1, 32'h84,       0, 0);
        // redirect inside DRAIN overwrites the target
        step(0, 1, 0, 32'h0,        1, 32'h300,      0,   1, 32'h84,       1, 0, 32'h0,        1, 0);
        step(0, 1, 1, 32'h500,      0, 32'h0,        0,   1, 32'h84,       1, 0, 32'h0,        1, 0);
        step(0, 1, 0, 32'h0,        0, 32'h0,        1,   1, 32'h84,       1, 0, 32'h0,        0, 0);
        step(0, 1, 0, 32'h0,        0, 32'h0,        1,   1, 32'h500,      1, 1, 32'h504,      0, 0);
        // PC wrap
        step(0, 1, 0, 32'h0,        1, 32'hFFFF_FFFC,1,   1, 32'h504,      1, 0, 32'h0,        1, 0);
        step(0, 1, 0, 32'h0,        0, 32'h0,        1,   1, 32'hFFFF_FFFC,1, 1, 32'h0,        0, 0);
        step(0, 1, 0, 32'h0,        0, 32'h0,        1,   1, 32'h0,        1, 1, 32'h4,        0, 0);
        // misaligned jump target: low bits cleared, trap sticky when enabled
        step(0, 1, 0, 32'h0,        1, 32'h103,      1,   1, 32'h4,        1, 0, 32'h0,        1, 0);
        step(0, 1, 0, 32'h0,        0, 32'h0,        1,   1, 32'h100,      1, 1, 32'h104,      0, 1);
        // redirect out of HOLD while stalled
        step(0, 0, 0, 32'h0,        0, 32'h0,        1,   1, 32'h104,      1, 1, 32'h108,      0, 1);
        step(0, 0, 1, 32'h60,       0, 32'h0,        1,   0, 32'h0,        0, 0, 32'h0,        1, 1);
        step(0, 1, 0, 32'h0,        0, 32'h0,        1,   1, 32'h60,       1, 1, 32'h64,       0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
